// File: rtl/spi_flash_reader.sv
// spi_flash_reader
//   Reads one 32-bit word from a serial NOR flash using the 0x03 READ command
//   in SPI mode 0. A request is accepted in IDLE, the command byte and the
//   24-bit address go out MSB first, and then 32 data bits come back. Each
//   received byte arrives MSB first, and the first byte ends up in the least
//   significant byte of rsp_data.
//
//   state | meaning
//   IDLE  | req_ready high, waiting for req_valid
//   CMD   | shifting out the 8-bit READ command
//   ADDR  | shifting out the 24-bit address
//   DATA  | sampling 32 bits from spi_miso
//   GAP   | chip select high for CLK_DIV cycles before the next request
//
// Ports
//   clk, rst             single clock, asynchronous active-high reset
//   req_valid/req_ready  request handshake; req_addr is captured on accept
//   req_addr[23:0]       flash byte address, sent unmodified
//   rsp_valid            one-cycle pulse, rsp_data valid (held until the next pulse)
//   rsp_data[31:0]       read word, little-endian byte order
//   spi_cs_n/sck/mosi    flash interface outputs, all registered
//   spi_miso             flash serial data, sampled on SCK rising edges
module spi_flash_reader #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] HALF_LOAD = 8'(CLK_DIV - 1);
  localparam logic [5:0] LAST_BIT  = 6'd63;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;        // half-period down-counter, also times GAP
  logic [5:0]  bit_q;        // index of the SCK pulse in progress, 0..63
  logic [31:0] tx_q;         // command + address; bit 31 is on spi_mosi
  logic [31:0] rx_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        cs_n_q;
  logic        sck_q;
  logic        mosi_q;

  logic [5:0]  bit_d;
  logic [31:0] tx_d;
  logic [31:0] rx_d;
  logic [31:0] rsp_data_d;

  assign bit_d = bit_q + 6'd1;
  // Once command and address have shifted out, zeros fill in from the
  // bottom, which keeps spi_mosi low throughout DATA.
  assign tx_d  = {tx_q[30:0], 1'b0};
  assign rx_d  = {rx_q[30:0], spi_miso};
  // The first byte received sits in rx_q[31:24]; swap to little-endian.
  assign rsp_data_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            state_q     <= CMD;
            req_ready_q <= 1'b0;
            cs_n_q      <= 1'b0;
            sck_q       <= 1'b0;
            cnt_q       <= HALF_LOAD;
            bit_q       <= '0;
            tx_q        <= {CMD_READ, req_addr};
            mosi_q      <= CMD_READ[7];
          end else begin
            // Also covers the first edge after reset release.
            req_ready_q <= 1'b1;
          end
        end
        CMD, ADDR, DATA: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            cnt_q <= HALF_LOAD;
            if (!sck_q) begin
              sck_q <= 1'b1;
              if (state_q == DATA) begin
                rx_q <= rx_d;
              end
            end else begin
              // Falling edge: the only place mosi changes, so it is stable
              // for the whole high phase.
              sck_q <= 1'b0;
              if (bit_q == LAST_BIT) begin
                state_q     <= GAP;
                cs_n_q      <= 1'b1;
                mosi_q      <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rsp_data_d;
              end else begin
                bit_q  <= bit_d;
                tx_q   <= tx_d;
                mosi_q <= tx_d[31];
                if (bit_d == 6'd8) begin
                  state_q <= ADDR;
                end else if (bit_d == 6'd32) begin
                  state_q <= DATA;
                end
              end
            end
          end
        end
        GAP: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_sck   = sck_q;
  assign spi_mosi  = mosi_q;

endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 Parameter CLK_DIV, default 2, clk cycles per SCK half-period; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  word read request from the storage controller.
REQ-005 req_ready  output  1  block idle and able to accept a request.
REQ-006 req_addr  input  24  byte address in external flash; sent as-is, alignment not checked.
REQ-007 rsp_valid  output  1  one-cycle pulse marking rsp_data valid.
REQ-008 rsp_data  output  32  read word.
REQ-009 spi_cs_n  output  1  flash chip select, active-low.
REQ-010 spi_sck  output  1  SPI clock, mode 0 (idle low).
REQ-011 spi_mosi  output  1  serial data to flash.
REQ-012 spi_miso  input  1  serial data from flash.

Function
REQ-013 The state machine SHALL have states IDLE, CMD, ADDR, DATA, GAP.
REQ-014 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1, and req_addr is captured at that edge.
REQ-015 On acceptance: state becomes CMD, spi_cs_n=0 from the next cycle, and spi_mosi presents the MSB of command 0x03.
REQ-016 Each bit: spi_sck low for CLK_DIV cycles, then high for CLK_DIV cycles; spi_mosi changes only while spi_sck is low; spi_miso is sampled on the clk edge where spi_sck goes 0->1.
REQ-017 Bit order: CMD 8 bits (0x03), then ADDR 24 bits MSB first, then DATA 32 bits; 64 SCK pulses per transaction, no more, no fewer.
REQ-018 DATA bytes are received MSB first per byte; byte k (k=0..3, in arrival order) SHALL land in rsp_data[8k+7:8k] (little-endian).
REQ-019 spi_mosi SHALL be 0 during DATA and in IDLE/GAP.
REQ-020 spi_cs_n SHALL stay low for exactly 128*CLK_DIV cycles, then return to 1 with spi_sck=0.
REQ-021 rsp_valid SHALL pulse for exactly one cycle, in the first cycle spi_cs_n is 1 again; rsp_data SHALL hold its value until the next rsp_valid.
REQ-022 After the end of DATA, the block SHALL stay in GAP for CLK_DIV cycles with spi_cs_n=1, then return to IDLE; req_ready is 0 throughout GAP.
REQ-023 req_valid while req_ready=0 SHALL be ignored; it is not queued, and req_addr changes have no effect.
REQ-024 A request held through GAP SHALL be accepted on the first IDLE cycle, giving back-to-back transactions separated by CLK_DIV+1 cycles of spi_cs_n=1.
REQ-025 All outputs SHALL be registered, with no combinational path from spi_miso or req_* to any output.

Reset
REQ-026 While rst=1, and immediately on assertion even mid-transaction: state=IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, rsp_valid=0, rsp_data=0, req_ready=0.
REQ-027 req_ready SHALL rise on the first clk edge after rst deasserts.
REQ-028 A transaction interrupted by reset SHALL produce no rsp_valid, and no partial data SHALL appear on rsp_data.

Verification
REQ-029 CLK_DIV=2, req_addr=0x000100, flash model returns 0xEF,0xBE,0xAD,0xDE -> MOSI stream 0x03,0x00,0x01,0x00; spi_cs_n low 256 cycles; rsp_data=0xDEADBEEF with a one-cycle rsp_valid.
REQ-030 CLK_DIV=1, req_addr=0xFFFFFE, model returns 0x01,0x02,0x03,0x04 -> address bits 0xFFFFFE sent unmodified; spi_cs_n low 128 cycles; rsp_data=0x04030201.
REQ-031 req_valid held high across two requests (0x000000, then 0x000004) -> two transactions, spi_cs_n high for CLK_DIV+1 cycles between them, two rsp_valid pulses with the correct words.
REQ-032 req_valid toggled with different req_addr mid-transaction -> MOSI address bits unchanged, single rsp_valid.
REQ-033 rst asserted during DATA bit 10 -> spi_cs_n=1 and spi_sck=0 the same cycle, no rsp_valid, rsp_data=0, req_ready=1 one edge after release.
REQ-034 Checker on every transaction: exactly 64 SCK rising edges per spi_cs_n low window, spi_mosi stable while spi_sck=1, and high/low phases exactly CLK_DIV cycles each.
